// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type, widths and defaults for the I/D memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERR
    } state_t;

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: D-over-I port selection with a saturating anti-starvation counter.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic gnt_en,
    output logic sel_i,
    output logic sel_d
);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    always_comb begin
        starved = starve_cnt == CNT_W'(STARVE_MAX);
        sel_d   = gnt_en && d_req && !(i_req && starved);
        sel_i   = gnt_en && i_req && !sel_d;
    end

    // only D grants taken while I is waiting count toward starvation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (sel_i)
            starve_cnt <= '0;
        else if (sel_d && i_req && !starved)
            starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction and data ports onto one single-port memory,
// one transaction outstanding, with misaligned accesses answered locally with an error.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              sel_i, sel_d, grant, resp;
    logic              own_i, we_q;
    logic [ADDR_W-1:0] addr_q, gnt_addr;
    logic [DATA_W-1:0] wdata_q, rsp_data;

    // grants are masked while reset is asserted so every output reads 0
    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .gnt_en (state == IDLE && reset),
        .sel_i  (sel_i),
        .sel_d  (sel_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = misaligned(gnt_addr) ? ERR : ISSUE;
            ISSUE:   if (mem_gnt) state_nxt = WAIT;
            WAIT:    if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant     = sel_i || sel_d;
        gnt_addr  = sel_d ? d_addr : i_addr;
        i_gnt     = sel_i;
        d_gnt     = sel_d;
        mem_req   = state == ISSUE;
        mem_we    = mem_req && we_q;
        mem_addr  = mem_req ? addr_q : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        busy      = state != IDLE;
        resp      = (state == WAIT && mem_rvalid) || state == ERR;
        rsp_data  = (state == WAIT && !we_q) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_i   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            own_i   <= sel_i;
            we_q    <= sel_d && d_we;
            addr_q  <= gnt_addr;
            wdata_q <= sel_d ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            i_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= resp && own_i;
            i_err    <= state == ERR && own_i;
            i_rdata  <= (resp && own_i) ? rsp_data : '0;
            d_rvalid <= resp && !own_i;
            d_err    <= state == ERR && !own_i;
            d_rdata  <= (resp && !own_i) ? rsp_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a memory responder,
// checked against a transaction-level model of arbitration order and response data.
module tb_mem_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_err      (i_err),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_err      (d_err),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    typedef struct {
        bit          port_d;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rec_t;

    rec_t        gq[$];
    rec_t        rq[$];
    int          cyc = 0;
    int          mreq_rise = 0;
    int          n_mem = 0;
    int          exp_mem = 0;
    int          gnt_delay = 0;
    int          rv_delay = 1;
    int          streak = 0;
    logic [31:0] rmem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] ti_addr[$];
    logic [31:0] td_addr[$];
    logic [31:0] td_wdata[$];
    logic        td_we[$];

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // what a transaction must return, updating the reference memory as it goes
    function automatic rec_t predict(input bit pd, input logic [31:0] a, input logic we,
                                     input logic [31:0] wd);
        rec_t r = '{pd, 32'h0, 1'b0, 0};
        if (a[1:0] != 2'b00) r.err = 1'b1;
        else begin
            exp_mem++;
            if (we) model_mem[a] = wd;
            else r.data = model_mem.exists(a) ? model_mem[a] : hash(a);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = 32'h100 + ($urandom_range(0, 15) << 2);
        if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
        return a;
    endfunction

    task automatic clear_stim();
        ti_addr.delete();
        td_addr.delete();
        td_we.delete();
        td_wdata.delete();
    endtask

    task automatic add_d(input logic [31:0] a, input logic we, input logic [31:0] wd);
        td_addr.push_back(a);
        td_we.push_back(we);
        td_wdata.push_back(wd);
    endtask

    // memory: grant after gnt_delay waiting cycles, answer rv_delay cycles after grant
    initial begin : responder
        bit          pend = 0;
        int          wait_n = 0;
        int          rv_n = 0;
        logic [31:0] rd = '0;
        mem_gnt = 0;
        mem_rvalid = 0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 0;
            mem_rvalid = 0;
            mem_rdata = '0;
            if (pend) begin
                if (rv_n == 0) begin
                    mem_rvalid = 1;
                    mem_rdata = rd;
                    pend = 0;
                end else rv_n--;
            end else if (mem_req) begin
                if (wait_n >= gnt_delay) begin
                    mem_gnt = 1;
                    n_mem++;
                    wait_n = 0;
                    pend = 1;
                    rv_n = rv_delay - 1;
                    if (mem_we) begin
                        rmem[mem_addr] = mem_wdata;
                        rd = 32'h0BAD_0BAD;
                    end else rd = rmem.exists(mem_addr) ? rmem[mem_addr] : hash(mem_addr);
                end else wait_n++;
            end
        end
    end

    initial begin : monitor
        logic        p_req = 0, p_gnt = 0, p_we = 0;
        logic [31:0] p_addr = '0, p_wdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (i_gnt || d_gnt) begin
                check("one_gnt", 32'(i_gnt && d_gnt), 32'h0);
                gq.push_back('{d_gnt, 32'h0, 1'b0, cyc});
            end
            if (i_rvalid || d_rvalid) begin
                check("one_rvalid", 32'(i_rvalid && d_rvalid), 32'h0);
                rq.push_back('{d_rvalid, d_rvalid ? d_rdata : i_rdata, d_rvalid ? d_err : i_err, cyc});
            end
            if (mem_req && !p_req) mreq_rise = cyc;
            if (mem_req && p_req && !p_gnt) begin
                check("mem_addr_hold", mem_addr, p_addr);
                check("mem_wdata_hold", mem_wdata, p_wdata);
                check("mem_we_hold", 32'(mem_we), 32'(p_we));
            end
            p_req = mem_req;
            p_gnt = mem_gnt;
            p_we = mem_we;
            p_addr = mem_addr;
            p_wdata = mem_wdata;
        end
    end

    task automatic run(input int ni, input int nd, input string tag);
        rec_t ex[$];
        int   ri = 0, rd = 0, gi = 0, gd = 0, n = 0;
        int   mem0 = n_mem;
        logic got_i, got_d;
        exp_mem = 0;
        while (ri < ni || rd < nd) begin
            if (rd < nd && !(ri < ni && streak == SM)) begin
                if (ri < ni) streak = streak < SM ? streak + 1 : SM;
                ex.push_back(predict(1'b1, td_addr[rd], td_we[rd], td_wdata[rd]));
                rd++;
            end else begin
                streak = 0;
                ex.push_back(predict(1'b0, ti_addr[ri], 1'b0, 32'h0));
                ri++;
            end
        end
        @(posedge clk);
        #1;
        gq.delete();
        rq.delete();
        i_req = ni > 0;
        if (ni > 0) i_addr = ti_addr[0];
        d_req = nd > 0;
        if (nd > 0) begin
            d_addr = td_addr[0];
            d_we = td_we[0];
            d_wdata = td_wdata[0];
        end
        while ((gi < ni || gd < nd || rq.size() < ni + nd) && n < 300) begin
            @(negedge clk);
            got_i = i_gnt;
            got_d = d_gnt;
            @(posedge clk);
            #1;
            n++;
            if (got_i) begin
                gi++;
                if (gi < ni) i_addr = ti_addr[gi];
                else i_req = 0;
            end
            if (got_d) begin
                gd++;
                if (gd < nd) begin
                    d_addr = td_addr[gd];
                    d_we = td_we[gd];
                    d_wdata = td_wdata[gd];
                end else d_req = 0;
            end
        end
        repeat (3) @(negedge clk);
        check({tag, "_ngnt"}, gq.size(), ni + nd);
        check({tag, "_nrsp"}, rq.size(), ni + nd);
        check({tag, "_nmem"}, n_mem - mem0, exp_mem);
        for (int k = 0; k < ex.size() && k < gq.size() && k < rq.size(); k++) begin
            check({tag, "_gnt_port"}, 32'(gq[k].port_d), 32'(ex[k].port_d));
            check({tag, "_rsp_port"}, 32'(rq[k].port_d), 32'(ex[k].port_d));
            check({tag, "_rdata"}, rq[k].data, ex[k].data);
            check({tag, "_err"}, 32'(rq[k].err), 32'(ex[k].err));
            check({tag, "_rsp_after_gnt"}, 32'(rq[k].cyc > gq[k].cyc), 32'h1);
            if (k > 0) check({tag, "_one_outstanding"}, 32'(gq[k].cyc >= rq[k-1].cyc), 32'h1);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0;
        i_req = 1;
        i_addr = 32'h10;
        d_req = 1;
        d_we = 1;
        d_addr = 32'h20;
        d_wdata = 32'h1;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'(|{i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, i_rdata, d_rdata,
                                  mem_req, mem_we, mem_addr, mem_wdata, busy}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1;
        i_req = 0;
        d_req = 0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // lone fetch with immediate grant and one-cycle memory latency
        model_mem[32'h10] = 32'hDEAD_BEEF;
        rmem[32'h10] = 32'hDEAD_BEEF;
        clear_stim();
        ti_addr.push_back(32'h10);
        run(1, 0, "lone_i");
        if (gq.size() > 0 && rq.size() > 0) begin
            check("lone_i_rvalid_cycle", rq[0].cyc - gq[0].cyc, 32'd3);
            check("lone_i_memreq_cycle", mreq_rise - gq[0].cyc, 32'd1);
        end

        // simultaneous requests: D store first, then I
        clear_stim();
        add_d(32'h20, 1'b1, 32'h55);
        ti_addr.push_back(32'h24);
        run(1, 1, "both");
        check("store_reached_mem", rmem[32'h20], 32'h55);

        // continuous D traffic starves I for exactly SM grants
        clear_stim();
        ti_addr.push_back(32'h30);
        for (int k = 0; k < 6; k++) add_d(32'h140 + 4 * k, k[0], $urandom);
        run(1, 6, "starve");
        if (gq.size() > 4) check("starve_i_fifth", 32'(gq[4].port_d), 32'h0);
        clear_stim();
        ti_addr.push_back(32'h34);
        for (int k = 0; k < 5; k++) add_d(32'h160 + 4 * k, 1'b0, 32'h0);
        run(1, 5, "starve_again");

        // misaligned D load answers with an error and no memory access
        clear_stim();
        add_d(32'h13, 1'b0, 32'h0);
        run(0, 1, "misalign");
        if (gq.size() > 0 && rq.size() > 0)
            check("misalign_rvalid_cycle", rq[0].cyc - gq[0].cyc, 32'd2);

        // slow memory grant with a competing requester
        gnt_delay = 5;
        clear_stim();
        ti_addr.push_back(32'h40);
        add_d(32'h44, 1'b0, 32'h0);
        run(1, 1, "slow_gnt");
        gnt_delay = 0;

        // reset while waiting for the memory response
        rv_delay = 4;
        @(posedge clk);
        #1;
        i_req = 1;
        i_addr = 32'h80;
        @(negedge clk);
        check("rst_mid_gnt", 32'(i_gnt), 32'h1);
        @(posedge clk);
        #1;
        i_req = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'h1);
        #1;
        reset = 0;
        i_req = 1;
        d_req = 1;
        #1;
        check("rst_mid_outputs", 32'(|{i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, i_rdata, d_rdata,
                                      mem_req, mem_we, mem_addr, mem_wdata, busy}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1;
        i_req = 0;
        d_req = 0;
        streak = 0;
        rq.delete();
        repeat (8) @(negedge clk);
        check("rst_no_late_rsp", rq.size(), 32'd0);
        rv_delay = 1;
        clear_stim();
        ti_addr.push_back(32'h80);
        run(1, 0, "post_rst");

        // randomized traffic and memory timing
        for (int t = 0; t < 30; t++) begin
            int ni = $urandom_range(0, 2);
            int nd = $urandom_range(0, 5);
            if (ni + nd == 0) nd = 1;
            gnt_delay = $urandom_range(0, 3);
            rv_delay = $urandom_range(1, 3);
            clear_stim();
            for (int k = 0; k < ni; k++) ti_addr.push_back(rand_addr());
            for (int k = 0; k < nd; k++) add_d(rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            run(ni, nd, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive D-port grants while the I-port is waiting (range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  instruction-fetch read request; held until i_gnt.
REQ-005 i_addr  input  32  fetch byte address; stable while i_req is high and i_gnt is low.
REQ-006 i_gnt  output  1  request accepted this cycle.
REQ-007 i_rvalid / i_err  output  1 / 1  one-cycle response strobe / error flag.
REQ-008 i_rdata  output  32  fetched word; valid when i_rvalid is high.
REQ-009 d_req, d_we  input  1, 1  data request; we=1 store, we=0 load.
REQ-010 d_addr, d_wdata  input  32, 32  data address / store data; stable until d_gnt.
REQ-011 d_gnt, d_rvalid, d_err  output  1 each  D-port handshakes; same semantics as the I-port.
REQ-012 d_rdata  output  32  load data; 0 for stores.
REQ-013 mem_req, mem_we  output  1, 1  single-port memory request and write enable.
REQ-014 mem_addr, mem_wdata  output  32, 32  memory address / write data.
REQ-015 mem_gnt  input  1  memory accepted mem_req this cycle.
REQ-016 mem_rvalid, mem_rdata  input  1, 32  memory response, at least 1 cycle after mem_gnt.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and ERR, with at most one transaction outstanding.
REQ-019 In IDLE, x_gnt SHALL be combinational from x_req; address, write data and we SHALL be latched on grant, and the FSM moves to ISSUE, or to ERR when the address is misaligned (addr[1:0]!=0).
REQ-020 Arbitration SHALL favour D when both ports request, except when starve_cnt==STARVE_MAX, in which case I wins; only one x_gnt is high per cycle.
REQ-021 starve_cnt SHALL increment, saturating at STARVE_MAX, on each D grant while i_req is high, and SHALL clear on any I grant.
REQ-022 In ISSUE, mem_req SHALL be 1 with latched fields held stable until mem_gnt; on mem_gnt the FSM moves to WAIT.
REQ-023 In WAIT, on mem_rvalid the FSM SHALL register mem_rdata (0 for stores) to the grantee's rdata, pulse its rvalid for exactly 1 cycle next cycle with err=0, and return to IDLE.
REQ-024 A new grant SHALL be possible in the cycle the previous rvalid is high, so minimum grant-to-rvalid is 3 cycles when mem_gnt is immediate and mem_rvalid comes 1 cycle later.
REQ-025 ERR SHALL last 1 cycle with no memory access; next cycle the grantee sees rvalid=1, err=1, rdata=0, and the FSM returns to IDLE.
REQ-026 mem_rvalid outside WAIT SHALL be ignored, and mem_gnt outside ISSUE SHALL be ignored.
REQ-027 Responses SHALL be routed only to the port that owns the transaction, never to both.

Reset
REQ-028 When reset is low: state=IDLE; starve_cnt=0; all outputs 0, including mem_req, x_gnt, x_rvalid, x_err, x_rdata and busy.
REQ-029 Reset mid-transaction SHALL drop the transaction with no response, and a late mem_rvalid after reset SHALL not produce a response.

Structure
REQ-030 A shared package mem_arb_pkg SHALL hold the state enum, the STARVE_MAX default and the 32-bit width constants.
REQ-031 Port selection and the starvation counter SHALL live in sub-module mem_arb_prio (inputs: i_req, d_req, grant-enable; outputs: sel_i, sel_d).

Verification
REQ-032 Lone I load at 0x10, mem_rdata=0xDEADBEEF one cycle after mem_gnt -> i_gnt in cycle 0, mem_req in cycle 1, i_rvalid with 0xDEADBEEF in cycle 3.
REQ-033 Simultaneous i_req and d_req (store 0x55 to 0x20) -> D granted first, mem_we=1, d_rvalid with d_rdata=0; then I granted.
REQ-034 d_req continuously high plus i_req high, STARVE_MAX=4 -> exactly 4 D grants, then an I grant, then starve_cnt=0.
REQ-035 D load at 0x13 -> d_gnt, no mem_req, next cycle d_rvalid=1 and d_err=1 with d_rdata=0.
REQ-036 mem_gnt delayed 5 cycles -> mem_addr and mem_req held stable throughout; a second requester gets no grant until the response.
REQ-037 reset pulsed low during WAIT, then mem_rvalid -> no x_rvalid, all outputs 0, and the next request is served normally.
